// File: rtl/mac_array_acc_pkg.sv
// Shared op encodings, FSM state codes and mask/popcount helpers for the MAC array.
// Helpers work on a fixed 16x16 ceiling and are narrowed by a size cast at the call site.
package mac_acc_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'd0,
      OP_XNOR = 2'd1,
      OP_XOR  = 2'd2,
      OP_HOLD = 2'd3
   } op_e;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   localparam int MASK_MAX_DIM = 16;
   localparam int MASK_MAX     = MASK_MAX_DIM * MASK_MAX_DIM;
   localparam int MASK_IDX_W   = $clog2(MASK_MAX);

   // Bit r*kmax+c is set when row r and column c both fall inside the active ks x ks kernel.
   function automatic logic [MASK_MAX-1:0] kernel_mask(input int ks, input int kmax);
      logic [MASK_MAX-1:0] m;
      m = '0;
      for (int r = 0; r < MASK_MAX_DIM; r++) begin
         for (int c = 0; c < MASK_MAX_DIM; c++) begin
            if (r < ks && c < ks && r < kmax && c < kmax)
               m[MASK_IDX_W'(r * kmax + c)] = 1'b1;
         end
      end
      return m;
   endfunction

   function automatic int popcount(input logic [MASK_MAX-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < MASK_MAX; i++)
         n = n + int'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/mac_array_acc_if.sv
// Ifmap column input stream and psum output stream of the MAC array, both valid/ready.
// The slave side is the array; the master side is staging plus writeback.
interface mac_array_acc_if #(
   parameter int MAC_NUM = 256,
   parameter int KMAX    = 5,
   parameter int ACC_W   = 12
);
   logic                     in_valid;
   logic                     in_ready;
   logic [KMAX*MAC_NUM-1:0]  ifmap_col;
   logic                     out_valid;
   logic                     out_ready;
   logic [ACC_W*MAC_NUM-1:0] psum_out;

   modport master (
      output in_valid, ifmap_col, out_ready,
      input  in_ready, out_valid, psum_out
   );

   modport slave (
      input  in_valid, ifmap_col, out_ready,
      output in_ready, out_valid, psum_out
   );
endinterface

// File: rtl/mac_array_acc_lane.sv
// One MAC lane: weight + window registers, masked binary op, popcount, saturating accumulate.
// Accumulates on the same edge as the last column of a window; no backpressure of its own.
module mac_lane
   import mac_acc_pkg::*;
#(
   parameter int KMAX  = 5,
   parameter int ACC_W = 12,
   parameter int KS_W  = $clog2(KMAX + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 w_load,
   input  logic [KMAX*KMAX-1:0] w_dat,
   input  logic                 job_start,
   input  logic                 en_dat,
   input  logic                 col_we,
   input  logic [KS_W-1:0]      col_idx,
   input  logic [KMAX-1:0]      col_dat,
   input  logic                 acc_en,
   input  op_e                  op,
   input  logic [KMAX*KMAX-1:0] mask,
   output logic [ACC_W-1:0]     acc
);
   localparam int KK    = KMAX * KMAX;
   localparam int PC_W  = $clog2(KK + 1);
   localparam int SUM_W = ACC_W + 1;

   logic [KK-1:0]    weight;
   logic [KK-1:0]    window;
   logic [KK-1:0]    win_next;
   logic [KK-1:0]    f_out;
   logic             en_q;
   logic [PC_W-1:0]  pc;
   logic [SUM_W-1:0] sum;

   // The incoming column is folded in combinationally so the final beat of a window counts.
   for (genvar c = 0; c < KMAX; c++) begin : g_col
      for (genvar r = 0; r < KMAX; r++) begin : g_row
         assign win_next[r*KMAX + c] = (col_we && col_idx == KS_W'(c)) ?
                                       col_dat[r] : window[r*KMAX + c];
      end
   end

   always_comb begin
      case (op)
         OP_AND:  f_out = weight & win_next;
         OP_XNOR: f_out = ~(weight ^ win_next);
         OP_XOR:  f_out = weight ^ win_next;
         default: f_out = '0;
      endcase
   end

   assign pc  = PC_W'(popcount(MASK_MAX'(f_out & mask)));
   assign sum = {1'b0, acc} + SUM_W'(pc);

   always_ff @(posedge clk) begin
      if (rst) begin
         weight <= '0;
         window <= '0;
         en_q   <= 1'b0;
         acc    <= '0;
      end else begin
         if (w_load)
            weight <= w_dat;
         if (col_we)
            window <= win_next;
         if (job_start) begin
            en_q <= en_dat;
            acc  <= '0;
         end else if (acc_en && en_q) begin
            acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mac_array_acc.sv
// Binary MAC array: streams ks columns per window, accumulates acc_len windows per lane.
// out_valid 1 cycle after the last column; in_ready low outside LOAD, psum held until out_ready.
module mac_array_acc
   import mac_acc_pkg::*;
#(
   parameter int MAC_NUM = 256,
   parameter int KMAX    = 5,
   parameter int ACC_W   = 12,
   parameter int LEN_W   = 8,
   parameter int KS_W    = $clog2(KMAX + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_start,
   input  logic [1:0]                   cfg_operation,
   input  logic [KS_W-1:0]              cfg_kernel_size,
   input  logic [LEN_W-1:0]             cfg_acc_len,
   output logic                         cfg_err,
   input  logic [MAC_NUM-1:0]           enable,
   input  logic                         w_valid,
   input  logic [KMAX*KMAX*MAC_NUM-1:0] weight_in,
   mac_array_acc_if.slave               strm,
   output logic                         busy
);
   localparam int KK = KMAX * KMAX;

   logic [1:0]               state;
   op_e                      op_q;
   logic [KS_W-1:0]          ks_q;
   logic [KS_W-1:0]          col_cnt;
   logic [LEN_W-1:0]         len_q;
   logic [LEN_W-1:0]         win_cnt;
   logic                     cfg_ok;
   logic                     start_ok;
   logic                     w_load;
   logic                     beat;
   logic                     last_col;
   logic                     last_win;
   logic [KK-1:0]            mask;
   logic [ACC_W*MAC_NUM-1:0] psum;

   assign cfg_ok   = (cfg_kernel_size != '0) && (cfg_kernel_size <= KS_W'(KMAX)) &&
                     (cfg_acc_len != '0);
   assign start_ok = (state == ST_IDLE) && cfg_start && cfg_ok;
   assign w_load   = (state == ST_IDLE) && w_valid;
   assign beat     = strm.in_valid && strm.in_ready;
   assign last_col = beat && (col_cnt == ks_q - KS_W'(1));
   assign last_win = last_col && (win_cnt == len_q - LEN_W'(1));
   assign mask     = KK'(kernel_mask(int'(ks_q), KMAX));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         op_q    <= OP_AND;
         ks_q    <= '0;
         len_q   <= '0;
         col_cnt <= '0;
         win_cnt <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cfg_start) begin
                  if (cfg_ok) begin
                     op_q    <= op_e'(cfg_operation);
                     ks_q    <= cfg_kernel_size;
                     len_q   <= cfg_acc_len;
                     col_cnt <= '0;
                     win_cnt <= '0;
                     state   <= ST_LOAD;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (beat) begin
                  if (last_col) begin
                     col_cnt <= '0;
                     win_cnt <= win_cnt + LEN_W'(1);
                     if (last_win)
                        state <= ST_OUT;
                  end else begin
                     col_cnt <= col_cnt + KS_W'(1);
                  end
               end
            end
            ST_OUT: begin
               if (strm.out_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign strm.in_ready  = (state == ST_LOAD);
   assign strm.out_valid = (state == ST_OUT);
   assign strm.psum_out  = psum;
   assign busy           = (state != ST_IDLE);

   // Accumulators double as the output register; they only change during LOAD.
   for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
      mac_lane #(
         .KMAX  (KMAX),
         .ACC_W (ACC_W),
         .KS_W  (KS_W)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .w_load    (w_load),
         .w_dat     (weight_in[i*KK +: KK]),
         .job_start (start_ok),
         .en_dat    (enable[i]),
         .col_we    (beat),
         .col_idx   (col_cnt),
         .col_dat   (strm.ifmap_col[i*KMAX +: KMAX]),
         .acc_en    (last_col),
         .op        (op_q),
         .mask      (mask),
         .acc       (psum[i*ACC_W +: ACC_W])
      );
   end

endmodule

// File: doc/mac_array_acc.md
Name: mac_array_acc

Overview:
Parametrised successor of the binary MAC array: MAC_NUM lanes, each holding a KMAX×KMAX binary kernel. Each lane builds a window from streamed ifmap columns, computes a masked popcount (AND/XNOR/XOR) and accumulates it over a programmable number of windows (input channels) into a saturating ACC_W-bit psum. Inputs use valid/ready; results leave through a valid/ready output stage. Sits between preload/AXIS ifmap staging and the psum writeback path.

Parameters:
MAC_NUM, 256, number of lanes
KMAX, 5, maximum kernel dimension; window is KMAX×KMAX bits
ACC_W, 12, accumulator/psum width per lane
LEN_W, 8, width of cfg_acc_len
KS_W, $clog2(KMAX+1), width of kernel-size field

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_start  in  1  one-cycle pulse; latch cfg_* and begin a job
cfg_operation  in  2  0=AND, 1=XNOR, 2=XOR, 3=HOLD (adds 0)
cfg_kernel_size  in  KS_W  active kernel dimension ks, legal 1..KMAX
cfg_acc_len  in  LEN_W  windows per job, legal 1..2^LEN_W-1
cfg_err  out  1  one-cycle pulse on an illegal start
enable  in  MAC_NUM  per-lane enable, sampled at cfg_start
w_valid  in  1  load weight_in into all lanes (IDLE only)
weight_in  in  KMAX*KMAX*MAC_NUM  lane i bits [i*KMAX*KMAX +: KMAX*KMAX]; bit r*KMAX+c = row r, col c
in_valid  in  1  ifmap column valid
in_ready  out  1  column accepted when in_valid&in_ready
ifmap_col  in  KMAX*MAC_NUM  lane i bits [i*KMAX +: KMAX]; bit r = row r
out_valid  out  1  psum_out valid
out_ready  in  1  downstream accepts psum
psum_out  out  ACC_W*MAC_NUM  lane i bits [i*ACC_W +: ACC_W]
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all weights, windows, accumulators, col/window counters cleared; in_ready=0, out_valid=0, psum_out=0, cfg_err=0, busy=0.
- States: IDLE, LOAD, OUT.
- IDLE: w_valid=1 writes weights the same edge. cfg_start with ks in 1..KMAX and acc_len≠0 -> latch op/ks/acc_len/enable, clear accumulators and counters, go LOAD. Illegal ks (0 or >KMAX) or acc_len=0 -> cfg_err pulses the next cycle, stay IDLE. cfg_start and w_valid in the same cycle: both take effect, job uses the new weights.
- LOAD: in_ready=1. Each accepted beat writes ifmap_col into window column col_cnt (0..ks-1), col_cnt++. Columns ≥ ks are masked out, so no window clear is needed.
- On the beat with col_cnt=ks-1: each enabled lane adds popcount(f(w, window_next) & mask_ks) to its accumulator on that edge. window_next includes the current column. mask_ks = rows<ks and cols<ks. f: AND w&x; XNOR ~(w^x); XOR w^x; HOLD 0. col_cnt returns to 0 and win_cnt increments.
- When win_cnt reaches acc_len on that beat -> OUT next cycle.
- Latency: out_valid rises 1 cycle after the final accepted column.
- Accumulation saturates at 2^ACC_W-1 (no wrap). Disabled lanes keep 0.
- OUT: in_ready=0, out_valid=1, psum_out is the accumulators, stable until out_valid&out_ready. On acceptance -> IDLE, out_valid=0 next cycle. psum_out holds its last value in IDLE.
- In LOAD/OUT: cfg_start and w_valid are ignored (no cfg_err).
- in_valid with no in_ready: no effect.
- rst at any time: immediate return to the reset state; any partial job is discarded.
- Per-window popcount range is 0..KMAX²; adder width is $clog2(KMAX*KMAX+1), zero-extended to ACC_W.

Decomposition:
- Package mac_acc_pkg: op encodings (OP_AND/OP_XNOR/OP_XOR/OP_HOLD), state enum, kernel-mask function (ks -> KMAX² bits), popcount function.
- Sub-module mac_lane: holds weight, window, enable and accumulator; does masked op, popcount and saturating add.
- Top module: FSM, counters, handshakes, lane generate loop.

Test Plan:
- Bench config MAC_NUM=4, KMAX=5, ACC_W=12. Weights all 1, ifmap all 1, AND, ks=3, acc_len=2, 6 beats -> every lane psum=18; out_valid exactly 1 cycle after the 6th beat.
- Weights 0, ifmap 0, XNOR, ks=5, acc_len=1 -> psum=25. Same with XOR -> 0. HOLD -> 0.
- ACC_W=6, all ones, AND, ks=5, acc_len=3 -> psum=63 (saturated, not 75 mod 64).
- Two cases:
  - enable=4'b0101 -> lanes 1 and 3 read 0, lanes 0 and 2 read the full value.
  - out_ready low 5 cycles -> out_valid stays 1, psum stable, in_ready=0; cfg_start ignored.
- cfg_start with ks=0, ks=6 or acc_len=0 -> cfg_err single pulse, busy stays 0. A legal start afterwards proceeds normally.
- rst asserted mid-LOAD after 2 beats -> next cycle busy=0, psum_out=0; a fresh job gives the expected values with no residue.
